// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: drives the commit enable and detects halt conditions.
// Optional breakpoint logic is built only when CPU_RUN_BP_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned MAX_CYCLES  = 1024,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             startin,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc_current,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e           state_q;
    logic [2:0]       cause_q;
    logic [2:0]       cause_d;
    logic [CNT_W-1:0] icnt_q;
    logic [CNT_W-1:0] ccnt_q;

    logic active;
    logic opc_hit;
    logic bp_hit;
    logic lim_hit;
    logic stop;

    assign active  = (state_q == S_RUN) || (state_q == S_STEP);
    assign opc_hit = (instruction[31:26] == HALT_OPCODE);
    assign lim_hit = (ccnt_q >= CNT_W'(MAX_CYCLES));

`ifdef CPU_RUN_BP_EN
    logic bp_skip_q;
    logic unused_bits;

    assign bp_hit      = bp_valid && (pc_current == bp_addr) && !bp_skip_q;
    assign unused_bits = ^instruction[25:0];

    // Skip lets a resume step over a breakpoint sitting at the current PC.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            bp_skip_q <= 1'b0;
        end else if (state_q == S_IDLE && (run || step)) begin
            bp_skip_q <= 1'b1;
        end else if (active) begin
            bp_skip_q <= 1'b0;
        end
    end
`else
    logic unused_bits;

    assign bp_hit      = 1'b0;
    assign unused_bits = ^{instruction[25:0], pc_current, bp_addr, bp_valid};
`endif

    assign stop = active && (halt_req || opc_hit || bp_hit || lim_hit);

    always_comb begin
        cause_d = 3'd0;
        if (halt_req) begin
            cause_d = 3'd1;
        end else if (opc_hit) begin
            cause_d = 3'd2;
        end else if (bp_hit) begin
            cause_d = 3'd3;
        end else if (lim_hit) begin
            cause_d = 3'd4;
        end
    end

    assign cpu_en      = active && !stop;
    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign halt_cause  = cause_q;
    assign instr_count = icnt_q;
    assign cycle_count = ccnt_q;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state_q <= S_IDLE;
            cause_q <= 3'd0;
            icnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            if (cpu_en && icnt_q != {CNT_W{1'b1}}) begin
                icnt_q <= icnt_q + CNT_W'(1);
            end
            if (active && ccnt_q != {CNT_W{1'b1}}) begin
                ccnt_q <= ccnt_q + CNT_W'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_RUN;
                        cause_q <= 3'd0;
                    end else if (step) begin
                        state_q <= S_STEP;
                        cause_q <= 3'd0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_HALT;
                        cause_q <= cause_d;
                    end else if (!run) begin
                        state_q <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (stop) begin
                        state_q <= S_HALT;
                        cause_q <= cause_d;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle CPU datapath.
- Generates cpu_en, a commit enable. When cpu_en=0, the top level gates three things: the PC load, RegWrite and MemWrite.
- Detects halt conditions: external request, HALT opcode, PC breakpoint, cycle-limit watchdog.
- Keeps instruction and cycle counters for the testbench and debug.
- Sits beside PC/Control and observes pc_current and instruction.

Parameters:
MAX_CYCLES, 1024, watchdog limit on cycles spent in RUN/STEP
HALT_OPCODE, 6'h3F, instruction[31:26] value treated as HALT
CNT_W, 32, width of instr_count and cycle_count

Ports:
clk  input  1  system clock, rising edge
startin  input  1  asynchronous active-low reset
run  input  1  level; 1 = free-run requested
step  input  1  single-cycle pulse; execute one instruction
halt_req  input  1  level; stop before the current instruction commits
instruction  input  32  current instruction from InstructionMemory
pc_current  input  32  current PC value
bp_addr  input  32  breakpoint PC
bp_valid  input  1  breakpoint armed
cpu_en  output  1  commit enable for PC/RegWrite/MemWrite (combinational)
state  output  2  0=IDLE 1=RUN 2=STEP 3=HALT
halted  output  1  1 while state==HALT
halt_cause  output  3  0 none, 1 halt_req, 2 opcode, 3 breakpoint, 4 limit
instr_count  output  CNT_W  committed instructions
cycle_count  output  CNT_W  clocks spent in RUN or STEP

Behaviour:
- Reset (startin=0, async): state=IDLE, halt_cause=0, instr_count=0, cycle_count=0, bp_skip=0. cpu_en=0 follows immediately.
- Stop condition, evaluated combinationally only in RUN/STEP. stop = halt_req | opc_hit | bp_hit | lim_hit, where:
  - opc_hit: instruction[31:26]==HALT_OPCODE
  - bp_hit: bp_valid & pc_current==bp_addr & !bp_skip
  - lim_hit: cycle_count>=MAX_CYCLES
- Cause priority when several stop terms are true: halt_req > opcode > breakpoint > limit.
- cpu_en = (state==RUN | state==STEP) & !stop. A stopping instruction never commits.
- State transitions:
  - IDLE: run=1 -> RUN; else step=1 -> STEP (run wins if both are asserted). Either entry sets bp_skip=1 and clears halt_cause to 0.
  - RUN: stop -> HALT, latching the cause; else run=0 -> IDLE; else stay. bp_skip clears after the first RUN cycle. step is ignored in RUN.
  - STEP: stop -> HALT with cause; else -> IDLE after exactly one cycle with cpu_en=1. bp_skip is cleared on exit.
  - HALT: cpu_en=0. run=0 -> IDLE, with halt_cause retained until the next RUN/STEP entry. step is ignored while run=1.
- Resume semantics:
  - bp_skip lets execution resume past a breakpoint at the same PC.
  - A HALT opcode halts again on every resume; the PC never advances past it.
  - The watchdog is sticky: once lim_hit, every RUN/STEP entry halts in its first cycle with cause 4. Only startin recovers.
- Counters:
  - instr_count += 1 on each clk where cpu_en=1.
  - cycle_count += 1 on each clk where state is RUN or STEP, including the stopping cycle.
  - Both saturate at all-ones; they do not wrap.
- Reset mid-RUN: immediate IDLE with cpu_en=0. A partial commit is impossible because cpu_en drops asynchronously.

Optional Feature:
CPU_RUN_BP_EN
- Defined: breakpoint logic is present as described.
- Undefined: bp_hit is tied to 0 and bp_skip is removed. bp_addr/bp_valid remain as ports but are ignored. halt_cause never equals 3.

Test Plan:
1. Reset, then run=1 with program addi,addi,add then a HALT opcode at PC=12 -> cpu_en high for 3 cycles, then state=3, halt_cause=2, instr_count=3, cycle_count=4, cpu_en=0 at PC=12.
2. From IDLE, pulse step three times, 2 idle cycles apart -> exactly one cpu_en cycle per pulse; state sequence 2,0 each time; instr_count=3.
3. bp_addr=8, bp_valid=1, run -> halt at PC=8 with cause 3 and instr_count=2. Then run=0, run=1 -> PC 8 commits with no re-halt; next halt is on the opcode.
4. MAX_CYCLES=5, infinite loop, run=1 -> halt with cause 4 after cycle_count=5. run toggle -> immediate re-halt with cause 4 and no commit. startin pulse -> counters 0.
5. halt_req=1 and HALT opcode in the same RUN cycle -> cause=1, cpu_en=0 that cycle.
6. startin=0 asserted mid-RUN, asynchronously between edges -> cpu_en=0 and state=0 immediately; counters 0.
